muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit beside the ALU in the EX stage of the MIPS datapath. It takes the same operands (rs → In1, rt → In2).
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and owns the architectural HI/LO registers. These are read by MFHI/MFLO through the EX result mux.
- Asserts busy so the hazard unit stalls the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request qualifier for MD_OP; sampled on clk rising edge.
- MD_OP  input  3  operation code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op. Codes live in defines.vh as `MD_*.
- In1  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source).
- In2  input  WIDTH  rt operand (multiplier / divisor).
- HI  output  WIDTH  HI register (product upper half / remainder).
- LO  output  WIDTH  LO register (product lower half / quotient).
- busy  output  1  operation in flight; the pipeline must not issue another start or MFHI/MFLO.
- done  output  1  one-cycle pulse when HI/LO have just been updated by a mult/div.

Behaviour:
- Reset (asynchronous, active-high): clk and reset behave as already decided — one clock, asynchronous active-high reset.
  - State goes to IDLE. HI=0, LO=0, busy=0, done=0.
  - Iteration counter and working registers are cleared.
  - Reset mid-operation aborts the operation; no HI/LO update occurs.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, MD_OP in {0..3}:
  - On edge E0, latch operands into working registers.
  - For signed ops, latch magnitudes plus the result-sign and remainder-sign bits.
  - counter=0, go to RUN, busy=1 from the cycle after E0.
- IDLE, start=1, MD_OP=4 (MTHI) or 5 (MTLO):
  - On the same edge, HI<=In1 (or LO<=In1).
  - busy stays 0, done stays 0, single-cycle.
- IDLE, start=1, MD_OP 6-7: no effect.
- RUN:
  - One iteration per edge, E1..E32 (WIDTH edges).
  - Multiply: shift-add over a 2*WIDTH accumulator, unsigned magnitudes.
  - Divide: restoring shift-subtract, unsigned magnitudes.
  - After the WIDTH-th iteration, go to FIX.
- FIX, on edge E33:
  - Apply sign correction: negate the product if the signs differed; quotient sign = sign(In1) xor sign(In2); remainder sign = sign(In1).
  - Write HI/LO, done=1 for exactly one cycle, busy=0, go to IDLE.
- Latency: busy is high for exactly WIDTH+1 = 33 cycles. HI/LO hold new values starting the cycle after E33.
- start while busy is ignored for every MD_OP, including MTHI/MTLO. There is no queuing.
- A new start in the same cycle done=1 is accepted, because the FSM is in IDLE.
- Divide by zero (In2=0), signed or unsigned: full 33-cycle latency, then HI=In1 as latched and LO=all ones (0xFFFFFFFF). No exception is raised.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural result of magnitude arithmetic truncated to WIDTH.
- HI/LO hold their values in all cycles except the write edges. MFHI/MFLO reads during busy return the stale values.
- All arithmetic is unsigned internally. Signed behaviour is produced only by abs() at latch time and by the negate in FIX. Negation is two's complement at 2*WIDTH for products and at WIDTH for quotient/remainder.

Test Plan:
- Reset, then MULT In1=0xFFFFFFFF, In2=2 → busy high for 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU In1=0xFFFFFFFF, In2=2 → HI=0x00000001, LO=0xFFFFFFFE. DIVU In1=100, In2=7 → LO=14, HI=2.
- DIV In1=0xFFFFFFF9 (-7), In2=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV In1=7, In2=0xFFFFFFFE (-2) → LO=0xFFFFFFFD, HI=1.
- DIVU In1=0x1234, In2=0 → after 33 cycles HI=0x1234, LO=0xFFFFFFFF.
- MTHI In1=0xAAAA5555 while idle → HI=0xAAAA5555 next cycle, busy=0.
- MTHI again during a running MULT → HI unchanged until the MULT result lands.
- Start MULTU 3*5, then assert start with DIVU 9/3 at cycle 10 → second request is ignored, and the result is HI=0, LO=15.
- Start MULT, assert reset at cycle 12 → busy=0, HI=LO=0 immediately.
- After reset releases, a new MULTU 6*7 completes with LO=42.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. Owns the architectural
// HI/LO registers. MULT/MULTU use shift-add and DIV/DIVU use restoring
// shift-subtract, both on unsigned magnitudes. One iteration runs per clock.
// Signs are stripped when the operands are latched and restored in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MD_OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  // Operation codes shared with the decoder (`MD_* in defines.vh).
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e             state;
  logic [CW-1:0]      cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;     // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_res;  // product or quotient must be negated
  logic               neg_rem;  // remainder must be negated
  logic               div0;     // divisor was zero
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

  // Operand magnitudes and sign bits, used at the latch edge.
  logic             op_signed;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Strip the signs from the operands of MULT and DIV.
  always_comb begin
    op_signed = (MD_OP == OP_MULT) || (MD_OP == OP_DIV);
    sgn_a     = op_signed & In1[WIDTH-1];
    sgn_b     = op_signed & In2[WIDTH-1];
    mag_a     = sgn_a ? -In1 : In1;
    mag_b     = sgn_b ? -In2 : In2;
  end

  // Iteration datapath: the next accumulator value for one shift-add or shift-subtract step.
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     upper;
  logic               ge;
  logic [WIDTH-1:0]   rem_n;

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    acc_next = acc;
    sum      = '0;
    upper    = '0;
    ge       = 1'b0;
    rem_n    = '0;
    if (is_div) begin
      upper    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      ge       = (upper >= {1'b0, opnd});
      rem_n    = ge ? WIDTH'(upper - {1'b0, opnd}) : upper[WIDTH-1:0];
      acc_next = {rem_n, acc[WIDTH-2:0], ge};
    end else begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes before they are written to HI/LO.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod   = neg_res ? -acc : acc;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      // A zero divisor gives an all-ones quotient whatever the signs are.
      fix_lo = (neg_res && !div0) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  // Control FSM with the working registers and the HI/LO/busy/done registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // registers update together on the edge, whatever order the statements are in.
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (MD_OP)
              OP_MULT, OP_MULTU: begin
                acc     <= {{WIDTH{1'b0}}, mag_b};
                opnd    <= mag_a;
                is_div  <= 1'b0;
                neg_res <= sgn_a ^ sgn_b;
                neg_rem <= 1'b0;
                div0    <= 1'b0;
                cnt     <= '0;
                busy_q  <= 1'b1;
                state   <= S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                acc     <= {{WIDTH{1'b0}}, mag_a};
                opnd    <= mag_b;
                is_div  <= 1'b1;
                neg_res <= sgn_a ^ sgn_b;
                neg_rem <= sgn_a;
                div0    <= (In2 == '0);
                cnt     <= '0;
                busy_q  <= 1'b1;
                state   <= S_RUN;
              end
              OP_MTHI: hi_q <= In1;
              OP_MTLO: lo_q <= In1;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) state <= S_FIX;
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. A vector table covers the mult/div
// results, and hand-written sequences cover MTHI/MTLO, ignored starts, a start
// taken in the done cycle, and reset in the middle of an operation.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   MD_OP;
  logic [W-1:0] In1, In2;
  logic [W-1:0] HI, LO;
  logic         busy, done;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .MD_OP(MD_OP),
    .In1(In1), .In2(In2), .HI(HI), .LO(LO), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drives one request at the current time (a negedge) and holds it for one edge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; MD_OP = op; In1 = a; In2 = b;
    @(posedge clk); #1;
    start = 1'b0; MD_OP = 3'd7;
  endtask

  // Counts the busy negedges until busy drops. Then checks done and the
  // scoreboard head against HI/LO. Returns at the negedge after the result edge.
  task automatic wait_result(input string name, output int nbusy);
    exp_t e;
    bit   ok;
    nbusy = 0;
    ok    = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      else begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL %s timeout: busy still high after 100 cycles", name);
    end
    check({name, " done"}, 64'(done), 64'd1);
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: scoreboard empty at result", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " HI"}, 64'(HI), 64'(e.hi));
      check({name, " LO"}, 64'(LO), 64'(e.lo));
    end
  endtask

  vec_t vecs[$];
  int   nb, nb2;

  initial begin
    vecs = '{
      '{3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE},  // MULT -1*2
      '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE},  // MULTU
      '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14},        // DIVU
      '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},  // DIV -7/2
      '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD},  // DIV 7/-2
      '{3'd3, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF},  // DIVU /0
      '{3'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF},  // DIV -5/0
      '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000},  // DIV overflow
      '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},  // MULT min*min
      '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1},  // MULT -3*5
      '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001}   // MULTU max*max
    };

    reset = 1'b1; start = 1'b0; MD_OP = 3'd7; In1 = '0; In2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset HI", 64'(HI), 64'd0);
    check("reset LO", 64'(LO), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);

    // Table-driven mult/div results and latency.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      exp_q.push_back('{hi: vecs[i].hi, lo: vecs[i].lo});
      wait_result($sformatf("vec%0d", i), nb);
      check($sformatf("vec%0d busy cycles", i), 64'(nb), 64'd33);
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), 64'(done), 64'd0);
    end

    // MTHI and MTLO while idle take effect in a single cycle.
    issue(3'd4, 32'hAAAA5555, 32'd0);
    @(negedge clk);
    check("mthi HI", 64'(HI), 64'hAAAA5555);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);
    issue(3'd5, 32'h13572468, 32'd0);
    @(negedge clk);
    check("mtlo LO", 64'(LO), 64'h13572468);
    check("mtlo HI kept", 64'(HI), 64'hAAAA5555);

    // An MTHI issued during a running MULT is ignored.
    issue(3'd0, 32'd3, 32'd4);
    exp_q.push_back('{hi: 32'd0, lo: 32'd12});
    repeat (5) @(negedge clk);
    issue(3'd4, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    check("mthi while busy HI stale", 64'(HI), 64'hAAAA5555);
    check("mthi while busy LO stale", 64'(LO), 64'h13572468);
    wait_result("mult after mthi", nb);

    // A DIVU issued at cycle 10 of a MULTU is dropped, and the latency is unchanged.
    @(negedge clk);
    issue(3'd1, 32'd3, 32'd5);
    exp_q.push_back('{hi: 32'd0, lo: 32'd15});
    nb2 = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) nb2++;
    end
    issue(3'd3, 32'd9, 32'd3);
    wait_result("multu ignore divu", nb);
    check("multu ignore divu cycles", 64'(nb + nb2), 64'd33);

    // A start presented in the done cycle is accepted.
    issue(3'd1, 32'd2, 32'd3);
    exp_q.push_back('{hi: 32'd0, lo: 32'd6});
    wait_result("multu 2*3", nb);
    issue(3'd3, 32'd50, 32'd8);
    exp_q.push_back('{hi: 32'd2, lo: 32'd6});
    @(negedge clk);
    check("start on done accepted", 64'(busy), 64'd1);
    wait_result("divu 50/8 back to back", nb);
    check("back to back cycles", 64'(nb + 1), 64'd33);

    // Reset in the middle of a MULT aborts it at once.
    @(negedge clk);
    issue(3'd0, 32'd1000, 32'd1000);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort HI", 64'(HI), 64'd0);
    check("abort LO", 64'(LO), 64'd0);
    check("abort done", 64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(3'd1, 32'd6, 32'd7);
    exp_q.push_back('{hi: 32'd0, lo: 32'd42});
    wait_result("multu 6*7 after reset", nb);
    check("multu 6*7 cycles", 64'(nb), 64'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
